// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- 8N1 serial transmitter with a write buffer in front of the FSM.
//
// Frame: one start bit (0), eight data bits LSB first, one stop bit (1).
// Every bit lasts CLKS_PER_BIT clock cycles, so a frame is 10*CLKS_PER_BIT.
// Back-to-back frames are sent with no idle cycle between them.
//
// Build option:
//   UART_TX_FIFO_EN defined   -> the buffer is a FIFO_DEPTH-entry FIFO
//   UART_TX_FIFO_EN undefined -> the buffer is a single holding register
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    FIFO entries, power of two >= 2 (FIFO build only)
//
// Ports:
//   clk       in   system clock, all state on the rising edge
//   rst       in   asynchronous active-high reset
//   wr_data   in   [7:0] byte to transmit
//   wr_valid  in   wr_data is valid this cycle
//   wr_ready  out  buffer can take a byte this cycle (registered state only)
//   tx        out  serial line, idle high, driven straight from a flop
//   busy      out  registered: a byte is buffered or a frame is in flight
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic       tx,
  output logic       busy
);

  // Parameter legality is checked at elaboration so a bad configuration
  // cannot silently build a broken transmitter.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be 2 or greater");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx: FIFO_DEPTH must be a power of two, 2 or greater");
  end

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Buffer interface shared by both build options
  // ---------------------------------------------------------------------------
  logic       push;         // byte accepted this edge
  logic       pop;          // head byte moved into the shift register
  logic       buf_empty;    // current occupancy is zero
  logic       buf_full;     // current occupancy is at capacity
  logic       buf_empty_d;  // occupancy after this edge is zero
  logic [7:0] head_data;    // oldest buffered byte

  // A full buffer refuses a push even if the FSM pops on the same edge:
  // wr_ready must not depend on the FSM's combinational pop.
  assign wr_ready = ~buf_full;
  assign push     = wr_valid & ~buf_full;

`ifdef UART_TX_FIFO_EN
  // ---------------------------------------------------------------------------
  // FIFO: pointers carry one extra bit so full and empty differ.
  // ---------------------------------------------------------------------------
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  assign buf_empty   = (wr_ptr_q == rd_ptr_q);
  assign buf_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_ptr_d    = wr_ptr_q + PW'(push);
  assign rd_ptr_d    = rd_ptr_q + PW'(pop);
  assign buf_empty_d = (wr_ptr_d == rd_ptr_d);
  assign head_data   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; equal pointers already mark every entry as
  // invalid, and a reset-free array maps onto plain RAM/flops without a mux.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Single holding register: a push only happens when it is empty and a pop
  // only when it is full, so the two never coincide.
  // ---------------------------------------------------------------------------
  logic [7:0] hold_q;
  logic       hold_valid_q, hold_valid_d;

  assign buf_empty    = ~hold_valid_q;
  assign buf_full     = hold_valid_q;
  assign hold_valid_d = push | (hold_valid_q & ~pop);
  assign buf_empty_d  = ~hold_valid_d;
  assign head_data    = hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      if (push) begin
        hold_q <= wr_data;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  // NOTE: every variable gets a default before the case so no path through
  // this block leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (!buf_empty) begin
          pop     = 1'b1;
          shift_d = head_data;
          state_d = START;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // shift_q[0] is on the line now; bit 1 is the next one out.
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (!buf_empty) begin
            pop     = 1'b1;
            shift_d = head_data;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // busy is registered from next-state values so it lines up with tx.
  assign busy_d = ~buf_empty_d | (state_d != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // The async set of tx_q forces the line idle the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
